// File: rtl/usrt_cntr.sv
// Bit-slot counter for a USRT transmit framer: steps once per en_usrt rising
// edge through start, data, optional parity and stop slots, flagging the last.
module usrt_cntr #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       START,
  input  logic       par_en,
  input  logic       en_usrt,
  input  logic       RTS,
  output logic       max,
  output logic [5:0] cout
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [5:0] BASE_LAST = 6'(DATA_BITS + STOP_BITS);

  state_t     state_q, state_d;
  logic [5:0] cout_q, cout_d;
  logic       par_l_q, par_l_d;
  logic       en_q;
  logic       step;
  logic [5:0] last;

  assign step = en_usrt & ~en_q;
  assign last = BASE_LAST + {5'b0, par_l_q};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cout_q  <= '0;
      par_l_q <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cout_q  <= cout_d;
      par_l_q <= par_l_d;
      en_q    <= en_usrt;
    end
  end

  always_comb begin
    state_d = state_q;
    cout_d  = cout_q;
    par_l_d = par_l_q;
    unique case (state_q)
      IDLE: begin
        cout_d = '0;
        if (step && START && RTS) begin
          par_l_d = par_en;
          state_d = RUN;
        end
      end
      RUN: begin
        if (step) begin
          if (cout_q != last) begin
            cout_d = cout_q + 6'd1;
          end else begin
            // frame boundary: either chain straight into the next frame or stop
            cout_d = '0;
            if (START && RTS) par_l_d = par_en;
            else              state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cout = cout_q;
    max  = 1'b0;
    if (state_q == RUN && cout_q == last) max = 1'b1;
  end

endmodule

// File: tb/tb_usrt_cntr.sv
// Self-checking bench for usrt_cntr: directed phases plus randomized traffic,
// compared every clock against a frame-level reference model.
module tb_usrt_cntr;

  localparam int unsigned DB = 8;
  localparam int unsigned SB = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       START = 1'b0;
  logic       par_en = 1'b0;
  logic       en_usrt = 1'b0;
  logic       RTS = 1'b0;
  logic       max;
  logic [5:0] cout;

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  bit m_busy = 0;
  int m_pos = 0;
  bit m_par = 0;
  bit m_en_prev = 0;

  usrt_cntr #(.DATA_BITS(DB), .STOP_BITS(SB)) dut (
    .clk(clk), .rst(rst), .START(START), .par_en(par_en),
    .en_usrt(en_usrt), .RTS(RTS), .max(max), .cout(cout)
  );

  always #5 clk = ~clk;

  function automatic int frame_slots(bit par);
    return 1 + DB + int'(par) + SB;
  endfunction

  function automatic void model_reset();
    m_busy = 0; m_pos = 0; m_par = 0; m_en_prev = 0;
  endfunction

  // one rising clock as seen by the frame model
  function automatic void model_clock();
    bit step;
    if (!rst) begin
      model_reset();
      return;
    end
    step = en_usrt && !m_en_prev;
    m_en_prev = en_usrt;
    if (!step) return;
    if (!m_busy) begin
      if (START && RTS) begin
        m_busy = 1; m_pos = 0; m_par = par_en;
      end
    end else if (m_pos + 1 < frame_slots(m_par)) begin
      m_pos++;
    end else begin
      m_pos = 0;
      if (START && RTS) m_par = par_en;
      else              m_busy = 0;
    end
  endfunction

  task automatic check(string tag);
    int  exp_cout;
    bit  exp_max;
    exp_cout = m_busy ? m_pos : 0;
    exp_max  = m_busy && (m_pos == frame_slots(m_par) - 1);
    vectors++;
    assert (cout === 6'(exp_cout)) else begin
      miscompares++;
      $error("FAIL %s cout observed=%0d expected=%0d", tag, cout, exp_cout);
    end
    vectors++;
    assert (max === exp_max) else begin
      miscompares++;
      $error("FAIL %s max observed=%0b expected=%0b", tag, max, exp_max);
    end
  endtask

  task automatic cycle(string tag);
    @(posedge clk);
    model_clock();
    #1;
    check(tag);
  endtask

  task automatic pulse(string tag, int hi, int lo);
    en_usrt = 1'b1;
    for (int i = 0; i < hi; i++) cycle(tag);
    en_usrt = 1'b0;
    for (int i = 0; i < lo; i++) cycle(tag);
  endtask

  task automatic run_to(string tag, int target);
    bit found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      pulse(tag, 1, 1);
      if (m_busy && m_pos == target) found = 1;
    end
    vectors++;
    assert (found) else begin
      miscompares++;
      $error("FAIL %s_timeout reached=%0b required=1", tag, found);
    end
  endtask

  initial begin
    // reset held with enable toggling and a pending request
    START = 1'b1; RTS = 1'b1;
    #1;
    check("reset_idle");
    for (int i = 0; i < 6; i++) pulse("reset_hold", 1, 1);

    // continuous frames without parity
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
    par_en = 1'b0;
    for (int i = 0; i < 25; i++) pulse("cont_nopar", 1, 1);

    // parity frames, par_en toggled mid-frame at random, random enable widths
    par_en = 1'b1;
    run_to("par_sync", 0);
    for (int i = 0; i < 30; i++) begin
      if (m_pos > 0 && m_pos < 8) par_en = 1'($urandom);
      else                        par_en = 1'b1;
      pulse("parity", $urandom_range(1, 3), $urandom_range(1, 2));
    end

    // stop request mid-frame
    par_en = 1'b0;
    run_to("stop_seek", 4);
    START = 1'b0;
    for (int i = 0; i < 15; i++) pulse("stop_req", 1, 1);

    // flow control blocks a start in IDLE
    START = 1'b1; RTS = 1'b0;
    for (int i = 0; i < 4; i++) pulse("rts_idle", 1, 1);
    RTS = 1'b1;
    pulse("rts_start", 1, 1);
    run_to("rts_seek", 5);
    RTS = 1'b0;
    for (int i = 0; i < 15; i++) pulse("rts_mid", 1, 1);

    // asynchronous reset between clock edges
    RTS = 1'b1;
    run_to("arst_seek", 6);
    #3;
    rst = 1'b0;
    model_reset();
    #1;
    check("arst_now");
    for (int i = 0; i < 3; i++) pulse("arst_hold", 1, 1);
    rst = 1'b1;
    pulse("arst_restart", 1, 1);

    // randomized traffic
    for (int i = 0; i < 200; i++) begin
      START  = ($urandom_range(0, 7) != 0);
      RTS    = ($urandom_range(0, 5) != 0);
      par_en = 1'($urandom);
      pulse("random", $urandom_range(1, 4), $urandom_range(1, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
